// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and constants for the unified-memory arbiter
package arm_mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;
  localparam int INSTR_W = 32;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants made while fetch waits
module arb_starve_ctr #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic         at_max,
  output logic [W-1:0] cnt
);
  assign at_max = cnt == W'(MAX);
  // count up to MAX and hold there; clear wins over increment
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one memory between fetch and data ports
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [INSTR_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  state_e state, state_n;
  owner_e owner;
  logic we_q, flush_pend, if_cand, pick_if, win, ack, sup, at_max;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [$clog2(STARVE_MAX+1)-1:0] starve_cnt;

  assign if_cand = if_req & ~if_flush;
  assign pick_if = if_cand & (~d_req | at_max);
  assign win = d_req | if_cand;
  assign ack = state == S_WAIT && mem_ack;
  assign sup = flush_pend | if_flush;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;

  // next state: arbitrate in idle, one issue cycle, wait for ack
  always_comb
    state_n = state == S_IDLE ? (win ? S_ISSUE : S_IDLE) :
              state == S_ISSUE ? S_WAIT : (mem_ack ? S_IDLE : S_WAIT);

  // memory strobes and grants are driven only during the issue cycle
  always_comb begin
    mem_en = state == S_ISSUE;
    if_gnt = mem_en && owner == OWN_IF;
    d_gnt = mem_en && owner == OWN_D;
    mem_we = d_gnt & we_q;
    mem_addr = addr_q;
    mem_wdata = wdata_q;
  end

  // capture the winning request so the requester may move on after its grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner <= OWN_IF;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && win) begin
      owner <= pick_if ? OWN_IF : OWN_D;
      we_q <= ~pick_if & d_we;
      addr_q <= pick_if ? if_addr : d_addr;
      wdata_q <= pick_if ? '0 : d_wdata;
    end

  // remember a flush of the in-flight fetch until the transaction retires
  always_ff @(posedge clk or posedge rst)
    if (rst) flush_pend <= 1'b0;
    else if (state_n == S_IDLE) flush_pend <= 1'b0;
    else if (state != S_IDLE && owner == OWN_IF && if_flush) flush_pend <= 1'b1;

  // register the response; read data holds between valid pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_valid <= ack && owner == OWN_IF && !sup;
      d_valid <= ack && owner == OWN_D;
      if (ack && owner == OWN_IF && !sup)
        if_rdata <= addr_q[2] ? mem_rdata[2*INSTR_W-1:INSTR_W] : mem_rdata[INSTR_W-1:0];
      if (ack && owner == OWN_D) d_rdata <= we_q ? '0 : mem_rdata;
    end

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(d_gnt & if_req),
    .clr(if_gnt | (d_gnt & ~if_req)),
    .at_max(at_max),
    .cnt(starve_cnt)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import arm_mem_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, if_flush = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [63:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    total++; if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we} !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=000000", {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we}); end
    total++; if (mem_addr !== 64'h0 || if_rdata !== 32'h0 || d_rdata !== 64'h0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, if_rdata, d_rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_load();
    d_req = 1; d_we = 0; d_addr = 64'h10;
    step();
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL load_gnt got=%b%b exp=10", d_gnt, if_gnt); end
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h10) begin bad++; $display("FAIL load_issue got en=%b we=%b addr=%h exp 1 0 10", mem_en, mem_we, mem_addr); end
    step();
    d_req = 0;
    total++; if (mem_en !== 1'b0 || d_valid !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL load_wait got en=%b v=%b g=%b exp 000", mem_en, d_valid, d_gnt); end
    step();
    mem_ack = 1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL load_early got=%b exp=0", d_valid); end
    step();
    mem_ack = 0; mem_rdata = 64'h0;
    total++; if (d_valid !== 1'b1 || d_rdata !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL load_valid got v=%b d=%h exp 1 deadbeef00000001", d_valid, d_rdata); end
    step();
    total++; if (d_valid !== 1'b0 || d_rdata !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL load_hold got v=%b d=%h exp 0 deadbeef00000001", d_valid, d_rdata); end
  endtask

  task automatic test_priority();
    if_req = 1; if_addr = 64'h4;
    d_req = 1; d_we = 1; d_addr = 64'h20; d_wdata = 64'h55;
    step();
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL prio_gnt got d=%b i=%b exp 1 0", d_gnt, if_gnt); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 64'h20 || mem_wdata !== 64'h55) begin bad++; $display("FAIL prio_store got we=%b a=%h w=%h exp 1 20 55", mem_we, mem_addr, mem_wdata); end
    step();
    d_req = 0; d_we = 0; mem_ack = 1; mem_rdata = 64'h9999_9999_9999_9999;
    step();
    mem_ack = 0;
    total++; if (d_valid !== 1'b1 || d_rdata !== 64'h0) begin bad++; $display("FAIL store_done got v=%b d=%h exp 1 0", d_valid, d_rdata); end
    step();
    total++; if (if_gnt !== 1'b1 || mem_addr !== 64'h4 || mem_we !== 1'b0) begin bad++; $display("FAIL fetch_issue got g=%b a=%h we=%b exp 1 4 0", if_gnt, mem_addr, mem_we); end
    step();
    if_req = 0; mem_ack = 1; mem_rdata = 64'h1111_2222_3333_4444;
    step();
    mem_ack = 0;
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h1111_2222) begin bad++; $display("FAIL fetch_hi got v=%b d=%h exp 1 11112222", if_valid, if_rdata); end
    total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL starve_clr1 got=%0d exp=0", dut.starve_cnt); end
  endtask

  task automatic test_starvation();
    bit exp_if [6] = '{0, 0, 0, 0, 1, 0};
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    if_req = 1; if_addr = 64'h8; d_req = 1; d_we = 0; d_addr = 64'h40;
    for (int g = 0; g < 6; g++) begin
      int n = 0;
      do begin step(); n++; end while (!(d_gnt | if_gnt) && n < 10);
      total++;
      if (!(d_gnt | if_gnt)) begin bad++; $display("FAIL starve_timeout grant=%0d got none exp a grant", g); end
      else if (if_gnt !== exp_if[g] || d_gnt === if_gnt) begin bad++; $display("FAIL starve_order grant=%0d got if=%b d=%b exp if=%b", g, if_gnt, d_gnt, exp_if[g]); end
      mem_ack = 1;
      step();
      if (g == 3) begin total++; if (dut.starve_cnt !== 3'd4) begin bad++; $display("FAIL starve_sat got=%0d exp=4", dut.starve_cnt); end end
      if (g == 4) begin total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL starve_clr got=%0d exp=0", dut.starve_cnt); end end
      step();
      mem_ack = 0;
    end
    d_req = 0; if_req = 0;
    total++; if (d_rdata !== 64'hAAAA_BBBB_CCCC_DDDD || if_rdata !== 32'hCCCC_DDDD) begin bad++; $display("FAIL starve_data got d=%h i=%h exp aaaabbbbccccdddd ccccdddd", d_rdata, if_rdata); end
    step();
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 64'h100;
    step();
    total++; if (if_gnt !== 1'b1 || mem_en !== 1'b1) begin bad++; $display("FAIL flushA_issue got g=%b en=%b exp 1 1", if_gnt, mem_en); end
    step();
    if_req = 0; if_flush = 1;
    step();
    if_flush = 0; mem_ack = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    mem_ack = 0;
    total++; if (if_valid !== 1'b0 || if_rdata !== 32'hCCCC_DDDD) begin bad++; $display("FAIL flushA_sup got v=%b d=%h exp 0 ccccdddd", if_valid, if_rdata); end
    if_req = 1; if_addr = 64'h108;
    step();
    total++; if (if_gnt !== 1'b1 || mem_addr !== 64'h108) begin bad++; $display("FAIL flushB_issue got g=%b a=%h exp 1 108", if_gnt, mem_addr); end
    step();
    if_req = 0; if_flush = 1; mem_ack = 1;
    step();
    if_flush = 0; mem_ack = 0;
    total++; if (if_valid !== 1'b0 || if_rdata !== 32'hCCCC_DDDD) begin bad++; $display("FAIL flushB_sup got v=%b d=%h exp 0 ccccdddd", if_valid, if_rdata); end
    if_req = 1; if_flush = 1;
    step();
    if_req = 0; if_flush = 0;
    total++; if (if_gnt !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL flush_idle got g=%b en=%b exp 0 0", if_gnt, mem_en); end
    d_req = 1; d_addr = 64'h30;
    step();
    d_req = 0;
    total++; if (d_gnt !== 1'b1 || mem_addr !== 64'h30) begin bad++; $display("FAIL flush_after got g=%b a=%h exp 1 30", d_gnt, mem_addr); end
    step();
    mem_ack = 1; mem_rdata = 64'h77;
    step();
    mem_ack = 0;
    total++; if (d_valid !== 1'b1 || d_rdata !== 64'h77 || if_valid !== 1'b0) begin bad++; $display("FAIL flush_after_v got dv=%b d=%h iv=%b exp 1 77 0", d_valid, d_rdata, if_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_addr = 64'h50;
    step();
    d_req = 0;
    step();
    #2 rst = 1;
    #1;
    total++; if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we} !== 6'b0 || mem_addr !== 64'h0 || d_rdata !== 64'h0 || if_rdata !== 32'h0) begin bad++; $display("FAIL rst_async got ctl=%b a=%h d=%h i=%h exp 0", {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we}, mem_addr, d_rdata, if_rdata); end
    @(negedge clk);
    rst = 0;
    step();
    mem_ack = 1; mem_rdata = 64'hFFFF;
    step();
    mem_ack = 0;
    total++; if (dut.state !== S_IDLE || d_valid !== 1'b0 || if_valid !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL rst_stray got st=%0d dv=%b iv=%b en=%b exp 0 0 0 0", dut.state, d_valid, if_valid, mem_en); end
    step();
    total++; if (d_valid !== 1'b0 || d_rdata !== 64'h0) begin bad++; $display("FAIL rst_stray2 got v=%b d=%h exp 0 0", d_valid, d_rdata); end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({if_gnt, d_gnt, if_valid, d_valid, mem_en} !== 5'b0) begin bad++; $display("FAIL stray_idle cyc=%0d got=%b exp=00000", i, {if_gnt, d_gnt, if_valid, d_valid, mem_en}); end
    end
    mem_ack = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_priority();
    test_starvation();
    test_flush();
    test_reset_mid();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
